// File: rtl/ddr2_pkg.sv
// Shared DDR2 command-issuer types: command codes, pin encodings, default timings.
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 2
`endif
`ifndef DRAM_ADDR_WIDTH
`define DRAM_ADDR_WIDTH 14
`endif

package ddr2_pkg;

    localparam int unsigned BaWidth   = `DRAM_BA_WIDTH;
    localparam int unsigned AddrWidth = `DRAM_ADDR_WIDTH;
    localparam int unsigned NumBanks  = 1 << BaWidth;
    // Address bit carrying the auto-precharge / all-banks flag
    localparam int unsigned ApBit     = 10;
    localparam int unsigned TimerW    = 8;

    typedef enum logic [2:0] {
        CmdNop  = 3'd0,
        CmdAct  = 3'd1,
        CmdRd   = 3'd2,
        CmdWr   = 3'd3,
        CmdPre  = 3'd4,
        CmdPrea = 3'd5,
        CmdRef  = 3'd6,
        CmdMrs  = 3'd7
    } cmd_e;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] PinsDesel = 4'b1111;
    localparam logic [3:0] PinsNop   = 4'b0111;
    localparam logic [3:0] PinsAct   = 4'b0011;
    localparam logic [3:0] PinsRd    = 4'b0101;
    localparam logic [3:0] PinsWr    = 4'b0100;
    localparam logic [3:0] PinsPre   = 4'b0010;
    localparam logic [3:0] PinsRef   = 4'b0001;
    localparam logic [3:0] PinsMrs   = 4'b0000;

    localparam int unsigned TRcdDefault    = 4;
    localparam int unsigned TRpDefault     = 4;
    localparam int unsigned TRasDefault    = 12;
    localparam int unsigned TRrdDefault    = 3;
    localparam int unsigned TCcdDefault    = 2;
    localparam int unsigned TWr2RdDefault  = 8;
    localparam int unsigned TWr2PreDefault = 10;
    localparam int unsigned TRfcDefault    = 26;
    localparam int unsigned TMrdDefault    = 2;

    // A timer loaded with P-1 reaches zero P-1 edges later, so the next command
    // may be accepted exactly P edges after the one that loaded it.
    function automatic logic [TimerW-1:0] timer_load(input int unsigned p);
        return (p == 0) ? '0 : TimerW'(p - 1);
    endfunction

    function automatic logic [TimerW-1:0] timer_dec(input logic [TimerW-1:0] t);
        return (t == '0) ? '0 : t - TimerW'(1);
    endfunction

endpackage

// File: rtl/ddr2_cmd_issuer_bank_timer.sv
// Per-bank open flag and same-bank timing counters (tRCD, tRAS, tRP, WR-to-PRE).
module ddr2_bank_timer
    import ddr2_pkg::*;
#(
    parameter int unsigned T_RCD    = TRcdDefault,
    parameter int unsigned T_RAS    = TRasDefault,
    parameter int unsigned T_RP     = TRpDefault,
    parameter int unsigned T_WR2PRE = TWr2PreDefault
) (
    input  logic clk,
    input  logic rst_n,
    input  logic do_act_i,
    input  logic do_wr_i,
    input  logic do_pre_i,
    output logic is_open_o,
    output logic act_ok_o,
    output logic rw_ok_o,
    output logic pre_ok_o
);

    logic              open_q, open_d;
    logic [TimerW-1:0] rcd_q, rcd_d;
    logic [TimerW-1:0] ras_q, ras_d;
    logic [TimerW-1:0] rp_q, rp_d;
    logic [TimerW-1:0] wr2pre_q, wr2pre_d;

    // Next state: counters count down, issued commands reload them
    always_comb begin
        open_d   = open_q;
        rcd_d    = timer_dec(rcd_q);
        ras_d    = timer_dec(ras_q);
        rp_d     = timer_dec(rp_q);
        wr2pre_d = timer_dec(wr2pre_q);
        if (do_act_i) begin
            open_d = 1'b1;
            rcd_d  = timer_load(T_RCD);
            ras_d  = timer_load(T_RAS);
        end
        if (do_wr_i) begin
            wr2pre_d = timer_load(T_WR2PRE);
        end
        if (do_pre_i) begin
            open_d = 1'b0;
            rp_d   = timer_load(T_RP);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q   <= 1'b0;
            rcd_q    <= '0;
            ras_q    <= '0;
            rp_q     <= '0;
            wr2pre_q <= '0;
        end else begin
            open_q   <= open_d;
            rcd_q    <= rcd_d;
            ras_q    <= ras_d;
            rp_q     <= rp_d;
            wr2pre_q <= wr2pre_d;
        end
    end

    // Timing-only readiness; open/closed legality is judged by the issuer
    always_comb begin
        is_open_o = open_q;
        act_ok_o  = (rp_q == '0);
        rw_ok_o   = (rcd_q == '0);
        pre_ok_o  = (ras_q == '0) && (wr2pre_q == '0);
    end

endmodule

// File: rtl/ddr2_cmd_issuer.sv
// DDR2 command issuer: legality/timing check on requests, registered command pins.
module ddr2_cmd_issuer
    import ddr2_pkg::*;
#(
    parameter int unsigned T_RCD    = TRcdDefault,
    parameter int unsigned T_RP     = TRpDefault,
    parameter int unsigned T_RAS    = TRasDefault,
    parameter int unsigned T_RRD    = TRrdDefault,
    parameter int unsigned T_CCD    = TCcdDefault,
    parameter int unsigned T_WR2RD  = TWr2RdDefault,
    parameter int unsigned T_WR2PRE = TWr2PreDefault,
    parameter int unsigned T_RFC    = TRfcDefault,
    parameter int unsigned T_MRD    = TMrdDefault
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_cmd,
    input  logic [BaWidth-1:0]   req_ba,
    input  logic [AddrWidth-1:0] req_addr,
    input  logic                 cke_en,
    input  logic                 odt_en,
    output logic                 err_illegal,
    output logic [NumBanks-1:0]  bank_open,
    output logic                 cs_n,
    output logic                 ras_n,
    output logic                 cas_n,
    output logic                 we_n,
    output logic [BaWidth-1:0]   ba,
    output logic [AddrWidth-1:0] addr,
    output logic                 cke,
    output logic                 odt
);

    cmd_e cmd;
    assign cmd = cmd_e'(req_cmd);

    logic [NumBanks-1:0] bk_open, bk_act_ok, bk_rw_ok, bk_pre_ok;
    logic [TimerW-1:0]   rrd_q, rrd_d, ccd_q, ccd_d, wr2rd_q, wr2rd_d, busy_q, busy_d;
    logic                illegal, timing_ok, issue, any_open, prea_ok;
    logic [3:0]          pins_q, pins_d;
    logic [BaWidth-1:0]  ba_q, ba_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic                err_q, cke_q, odt_q;

    for (genvar i = 0; i < NumBanks; i++) begin : g_bank
        logic hit;
        assign hit = (req_ba == BaWidth'(i));
        ddr2_bank_timer #(
            .T_RCD    (T_RCD),
            .T_RAS    (T_RAS),
            .T_RP     (T_RP),
            .T_WR2PRE (T_WR2PRE)
        ) u_bank (
            .clk       (clk),
            .rst_n     (rst_n),
            .do_act_i  (issue && (cmd == CmdAct) && hit),
            .do_wr_i   (issue && (cmd == CmdWr) && hit),
            .do_pre_i  (issue && (((cmd == CmdPre) && hit) || (cmd == CmdPrea))),
            .is_open_o (bk_open[i]),
            .act_ok_o  (bk_act_ok[i]),
            .rw_ok_o   (bk_rw_ok[i]),
            .pre_ok_o  (bk_pre_ok[i])
        );
    end

    assign any_open = |bk_open;
    // Closed banks never hold ras/wr2pre, but only open banks gate PREA anyway
    assign prea_ok  = &(bk_pre_ok | ~bk_open);

    // Legality (open/closed state) and timing readiness of the presented command
    always_comb begin
        illegal   = 1'b0;
        timing_ok = 1'b0;
        unique case (cmd)
            CmdNop: timing_ok = 1'b1;
            CmdAct: begin
                illegal   = bk_open[req_ba];
                timing_ok = bk_act_ok[req_ba] && (rrd_q == '0) && (busy_q == '0);
            end
            CmdRd: begin
                illegal   = !bk_open[req_ba];
                timing_ok = bk_rw_ok[req_ba] && (ccd_q == '0) && (wr2rd_q == '0)
                            && (busy_q == '0);
            end
            CmdWr: begin
                illegal   = !bk_open[req_ba];
                timing_ok = bk_rw_ok[req_ba] && (ccd_q == '0) && (busy_q == '0);
            end
            CmdPre: begin
                illegal   = !bk_open[req_ba];
                timing_ok = bk_pre_ok[req_ba] && (busy_q == '0);
            end
            CmdPrea: timing_ok = prea_ok && (busy_q == '0);
            CmdRef, CmdMrs: begin
                illegal   = any_open;
                timing_ok = (busy_q == '0);
            end
        endcase
    end

    assign req_ready = req_valid && (illegal || timing_ok);
    assign issue     = req_valid && !illegal && timing_ok && (cmd != CmdNop);

    // Global timer next state
    always_comb begin
        rrd_d   = timer_dec(rrd_q);
        ccd_d   = timer_dec(ccd_q);
        wr2rd_d = timer_dec(wr2rd_q);
        busy_d  = timer_dec(busy_q);
        if (issue) begin
            case (cmd)
                CmdAct: rrd_d = timer_load(T_RRD);
                CmdRd:  ccd_d = timer_load(T_CCD);
                CmdWr: begin
                    ccd_d   = timer_load(T_CCD);
                    wr2rd_d = timer_load(T_WR2RD);
                end
                CmdRef: busy_d = timer_load(T_RFC);
                CmdMrs: busy_d = timer_load(T_MRD);
                default: ;
            endcase
        end
    end

    // Pin next state: one cycle of command, otherwise NOP with ba/addr held
    always_comb begin
        pins_d = PinsNop;
        ba_d   = ba_q;
        addr_d = addr_q;
        if (issue) begin
            case (cmd)
                CmdAct: begin
                    pins_d = PinsAct;
                    ba_d   = req_ba;
                    addr_d = req_addr;
                end
                CmdRd, CmdWr: begin
                    pins_d        = (cmd == CmdRd) ? PinsRd : PinsWr;
                    ba_d          = req_ba;
                    addr_d        = req_addr;
                    addr_d[ApBit] = 1'b0;
                end
                CmdPre: begin
                    pins_d        = PinsPre;
                    ba_d          = req_ba;
                    addr_d        = req_addr;
                    addr_d[ApBit] = 1'b0;
                end
                CmdPrea: begin
                    pins_d        = PinsPre;
                    addr_d[ApBit] = 1'b1;
                end
                CmdRef: pins_d = PinsRef;
                CmdMrs: begin
                    pins_d = PinsMrs;
                    ba_d   = req_ba;
                    addr_d = req_addr;
                end
                default: ;
            endcase
        end
    end

    // Registered pins, global timers, error pulse and cke/odt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pins_q  <= PinsDesel;
            ba_q    <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            cke_q   <= 1'b0;
            odt_q   <= 1'b0;
            rrd_q   <= '0;
            ccd_q   <= '0;
            wr2rd_q <= '0;
            busy_q  <= '0;
        end else begin
            pins_q  <= pins_d;
            ba_q    <= ba_d;
            addr_q  <= addr_d;
            err_q   <= req_valid && illegal;
            cke_q   <= cke_en;
            odt_q   <= odt_en;
            rrd_q   <= rrd_d;
            ccd_q   <= ccd_d;
            wr2rd_q <= wr2rd_d;
            busy_q  <= busy_d;
        end
    end

    assign {cs_n, ras_n, cas_n, we_n} = pins_q;
    assign ba          = ba_q;
    assign addr        = addr_q;
    assign err_illegal = err_q;
    assign cke         = cke_q;
    assign odt         = odt_q;
    assign bank_open   = bk_open;

endmodule

// File: doc/ddr2_cmd_issuer.md
Name: ddr2_cmd_issuer

Overview:
Controller-side DDR2 command issuer that drives the command/address pins of the DIMM.
- Accepts abstract commands (ACT/RD/WR/PRE/PREA/REF/MRS) over a valid/ready handshake.
- Tracks per-bank open/closed state and enforces JEDEC timing with down-counters.
- Drives registered cs_n/ras_n/cas_n/we_n/ba/addr/cke/odt.
- Sits between the controller's request scheduler and the DIMM pins.

Parameters:
T_RCD, 4, ACT to RD/WR same bank (cycles)
T_RP, 4, PRE to ACT same bank
T_RAS, 12, ACT to PRE same bank
T_RRD, 3, ACT to ACT any bank
T_CCD, 2, RD/WR to RD/WR any bank
T_WR2RD, 8, WR to RD any bank (WL+BL/2+tWTR)
T_WR2PRE, 10, WR to PRE same bank (WL+BL/2+tWR)
T_RFC, 26, REF to any command
T_MRD, 2, MRS to any command

Ports:
clk  in  1  controller clock (DRAM ck is derived from it 1:1)
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  command request valid
req_ready  out  1  request consumed this cycle
req_cmd  in  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF, 7 MRS
req_ba  in  `DRAM_BA_WIDTH  bank address
req_addr  in  `DRAM_ADDR_WIDTH  row (ACT), column (RD/WR), mode value (MRS)
cke_en  in  1  requested CKE level
odt_en  in  1  requested ODT level
err_illegal  out  1  one-cycle pulse: illegal request consumed, not issued
bank_open  out  2**`DRAM_BA_WIDTH  per-bank open flag
cs_n, ras_n, cas_n, we_n  out  1 each  DRAM command pins
ba  out  `DRAM_BA_WIDTH  DRAM bank pins
addr  out  `DRAM_ADDR_WIDTH  DRAM address pins
cke, odt  out  1 each  registered copies of cke_en/odt_en

Behaviour:
- Reset: cs_n=1, ras_n=cas_n=we_n=1, ba=0, addr=0, cke=0, odt=0, err_illegal=0, bank_open=0, all timers 0.
- Reset is asynchronous. Mid-operation reset drops all state immediately.
- req_ready is combinational. It is 1 when req_valid and the command is timing-legal now, or when the command is illegal (consumed immediately).
- Illegal requests:
  - ACT to an open bank.
  - RD/WR/PRE to a closed bank.
  - REF or MRS while any bank is open.
  - An illegal request is consumed, the pins drive NOP, and err_illegal pulses the next cycle.
- Issue: an accepted legal command appears on the pins on the next clk edge (1-cycle latency). Pins hold for exactly one cycle, then revert to NOP (cs_n=0, ras_n=cas_n=we_n=1; ba/addr hold last value).
- Pin encoding (ras_n, cas_n, we_n):
  - ACT 011
  - RD 101
  - WR 100
  - PRE/PREA 010; addr[10]=0 for PRE, 1 for PREA
  - REF 001
  - MRS 000; ba selects MR/EMR
  - RD/WR force addr[10]=0 (no auto-precharge).
- cmd NOP with req_valid=1 is consumed with no pin activity.
- Timers: load P-1 on issue and decrement to 0 with saturation. A constrained command is legal only when every relevant timer is 0. P=1 therefore allows back-to-back commands.
  - Per-bank timers: rcd, ras, rp, wr2pre.
  - Global timers: rrd, ccd, wr2rd, busy (shared by REF→T_RFC and MRS→T_MRD).
  - While busy≠0, every command except NOP stalls.
- PREA:
  - Legal only if ras and wr2pre are 0 for all open banks.
  - Closes all banks and loads rp for every bank.
  - PREA with no bank open is legal and loads rp.
- bank_open updates on issue: set by ACT, cleared by PRE/PREA.
- Simultaneous new command and timer expiry: the legality check uses the current-cycle timer values. A timer reaching 0 this cycle permits issue next cycle.
- cke/odt are registered every cycle, independent of the handshake.

Decomposition:
- Shared package ddr2_pkg holds:
  - cmd_e enum (3-bit codes above).
  - Pin-encoding constants for the 4-bit {cs_n, ras_n, cas_n, we_n}.
  - Default timing localparams.
- Sub-module ddr2_bank_timer, instantiated per bank in a generate loop. It holds open state, rcd/ras/rp/wr2pre counters, and exports act_ok/rw_ok/pre_ok.

Test Plan:
- Reset then idle → pins 1111 during reset, NOP (0111) after; cke follows cke_en one cycle later.
- ACT ba=1 row 0x123, then RD ba=1 col 0x40 presented immediately → ACT pins next cycle; RD held off (req_ready=0) and issued exactly 4 cycles after ACT, addr[10]=0.
- ACT b0, ACT b1 back-to-back → second ACT appears 3 cycles after the first. PRE b0 at earliest 12 cycles after its ACT.
- WR b2 then RD b2 → RD pins 8 cycles after WR; PRE b2 no earlier than 10 cycles after WR.
- RD to closed bank 3 → consumed in 1 cycle, err_illegal pulses once, pins stay NOP, bank_open unchanged.
- All banks closed: REF then ACT b0 → ACT issued 26 cycles after REF. Reset asserted mid-wait → all timers and bank_open cleared, outputs at reset values.
